// File: rtl/ram_rw_check_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_rw_check_if
// Brief    : Single-port synchronous RAM bus between the self-test engine and RAM.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_rw_check_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) ();
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic [DATA_W-1:0] ram_rd_data;

    modport master (
        output ram_en,
        output ram_we,
        output ram_addr,
        output ram_wr_data,
        input  ram_rd_data
    );

    modport slave (
        input  ram_en,
        input  ram_we,
        input  ram_addr,
        input  ram_wr_data,
        output ram_rd_data
    );
endinterface
`default_nettype wire

// File: rtl/ram_rw_check.sv
`default_nettype none
// ============================================================================
// Module   : ram_rw_check
// Brief    : RAM write/read-back self-test engine with error count and status.
// Revision : 1.0 - initial release
// ============================================================================
module ram_rw_check #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 16
) (
    input  wire                sys_clk,
    input  wire                sys_rst_n,
    input  wire                start,
    input  wire                loop_en,
    ram_rw_check_if.master     ram,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [ADDR_W-1:0]  first_err_addr,
    output logic [15:0]        pass_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] c_last_addr  = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        c_drain_last = 2'(RD_LAT - 1);
    localparam logic [ERR_W-1:0]  c_err_max    = '1;

    state_t              state_q, state_d;
    logic                ram_en_q, ram_en_d;
    logic                ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_wr_data_q, ram_wr_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   first_err_addr_q, first_err_addr_d;
    logic [15:0]         pass_cnt_q, pass_cnt_d;
    logic [DATA_W-1:0]   offset_q, offset_d;
    logic [1:0]          drain_cnt_q, drain_cnt_d;

    // Read-compare pipeline: stage RD_LAT-1 lines up with ram_rd_data.
    logic                pipe_vld_q  [RD_LAT];
    logic                pipe_vld_d  [RD_LAT];
    logic [ADDR_W-1:0]   pipe_addr_q [RD_LAT];
    logic [ADDR_W-1:0]   pipe_addr_d [RD_LAT];
    logic [DATA_W-1:0]   pipe_exp_q  [RD_LAT];
    logic [DATA_W-1:0]   pipe_exp_d  [RD_LAT];

    logic                w_mismatch;

    always_comb begin
        pipe_vld_d[0]  = ram_en_q & ~ram_we_q;
        pipe_addr_d[0] = ram_addr_q;
        pipe_exp_d[0]  = DATA_W'(ram_addr_q) + offset_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
            pipe_exp_d[i]  = pipe_exp_q[i-1];
        end
    end

    assign w_mismatch = pipe_vld_q[RD_LAT-1] &&
                        (ram.ram_rd_data != pipe_exp_q[RD_LAT-1]);

    always_comb begin
        state_d          = state_q;
        ram_en_d         = 1'b0;
        ram_we_d         = 1'b0;
        ram_addr_d       = '0;
        ram_wr_data_d    = '0;
        done_d           = 1'b0;
        pass_d           = pass_q;
        pass_cnt_d       = pass_cnt_q;
        offset_d         = offset_q;
        drain_cnt_d      = '0;
        err_cnt_d        = err_cnt_q;
        first_err_addr_d = first_err_addr_q;

        if (w_mismatch) begin
            if (err_cnt_q != c_err_max) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            if (err_cnt_q == '0) begin
                first_err_addr_d = pipe_addr_q[RD_LAT-1];
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d          = S_WRITE;
                    ram_en_d         = 1'b1;
                    ram_we_d         = 1'b1;
                    offset_d         = DATA_W'(pass_cnt_q);
                    err_cnt_d        = '0;
                    first_err_addr_d = '0;
                end
            end
            S_WRITE: begin
                ram_en_d = 1'b1;
                if (ram_addr_q == c_last_addr) begin
                    state_d = S_READ;
                end else begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = ram_addr_q + ADDR_W'(1);
                end
            end
            S_READ: begin
                if (ram_addr_q == c_last_addr) begin
                    state_d = S_DRAIN;
                end else begin
                    ram_en_d   = 1'b1;
                    ram_addr_d = ram_addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == c_drain_last) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    pass_cnt_d = pass_cnt_q + 16'd1;
                    // Use the next count so the final compare is included.
                    pass_d     = (err_cnt_d == '0);
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            S_DONE: begin
                if (loop_en) begin
                    state_d          = S_WRITE;
                    ram_en_d         = 1'b1;
                    ram_we_d         = 1'b1;
                    offset_d         = DATA_W'(pass_cnt_q);
                    err_cnt_d        = '0;
                    first_err_addr_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ram_we_d) begin
            ram_wr_data_d = DATA_W'(ram_addr_d) + offset_d;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q          <= S_IDLE;
            ram_en_q         <= 1'b0;
            ram_we_q         <= 1'b0;
            ram_addr_q       <= '0;
            ram_wr_data_q    <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
            pass_cnt_q       <= '0;
            offset_q         <= '0;
            drain_cnt_q      <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_addr_q[i] <= '0;
                pipe_exp_q[i]  <= '0;
            end
        end else begin
            state_q          <= state_d;
            ram_en_q         <= ram_en_d;
            ram_we_q         <= ram_we_d;
            ram_addr_q       <= ram_addr_d;
            ram_wr_data_q    <= ram_wr_data_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            err_cnt_q        <= err_cnt_d;
            first_err_addr_q <= first_err_addr_d;
            pass_cnt_q       <= pass_cnt_d;
            offset_q         <= offset_d;
            drain_cnt_q      <= drain_cnt_d;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_d[i];
                pipe_addr_q[i] <= pipe_addr_d[i];
                pipe_exp_q[i]  <= pipe_exp_d[i];
            end
        end
    end

    assign ram.ram_en      = ram_en_q;
    assign ram.ram_we      = ram_we_q;
    assign ram.ram_addr    = ram_addr_q;
    assign ram.ram_wr_data = ram_wr_data_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_cnt_q;
    assign first_err_addr  = first_err_addr_q;
    assign pass_cnt        = pass_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_rw_check.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_rw_check
// Brief    : Scoreboard bench for ram_rw_check; two engines (RD_LAT 1 and 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_rw_check;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    typedef struct {
        logic [15:0]   err;
        logic [AW-1:0] first;
        logic          pass;
        logic [15:0]   pcnt;
    } res_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          loop_en;
    logic          skew;
    logic          const_ff;
    logic [DW-1:0] fault_mask [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int dut,
                       input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d actual=0x%0h expected=0x%0h", name, dut, act, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int RL   = (gi == 0) ? 1 : 2;
        localparam int EW   = (gi == 0) ? 16 : 4;
        localparam int PLEN = 2 * DEPTH + RL + 1;

        ram_rw_check_if #(.DATA_W(DW), .ADDR_W(AW)) ram_if ();

        logic          busy;
        logic          done;
        logic          pass;
        logic [EW-1:0] err_cnt;
        logic [AW-1:0] first_err_addr;
        logic [15:0]   pass_cnt;

        ram_rw_check #(
            .DATA_W (DW),
            .ADDR_W (AW),
            .DEPTH  (DEPTH),
            .RD_LAT (RL),
            .ERR_W  (EW)
        ) u_dut (
            .sys_clk        (clk),
            .sys_rst_n      (rst_n),
            .start          (start),
            .loop_en        (loop_en),
            .ram            (ram_if),
            .busy           (busy),
            .done           (done),
            .pass           (pass),
            .err_cnt        (err_cnt),
            .first_err_addr (first_err_addr),
            .pass_cnt       (pass_cnt)
        );

        // RAM: read-first, output register stages; latency RL or RL+1 (skew).
        logic [DW-1:0] mem     [DEPTH];
        logic [DW-1:0] rd_pipe [3];

        always @(posedge clk) begin
            if (ram_if.ram_en) begin
                if (ram_if.ram_we) mem[ram_if.ram_addr] <= ram_if.ram_wr_data;
                rd_pipe[0] <= const_ff ? {DW{1'b1}}
                                       : (mem[ram_if.ram_addr] | fault_mask[ram_if.ram_addr]);
            end
            rd_pipe[1] <= rd_pipe[0];
            rd_pipe[2] <= rd_pipe[1];
        end
        assign ram_if.ram_rd_data = skew ? rd_pipe[RL] : rd_pipe[RL-1];

        // Reference model: m_idx is the 1-based cycle within the pass, 0 when idle.
        int            m_idx;
        logic [15:0]   m_pcnt;
        logic [DW-1:0] m_off;
        int            m_err;
        logic [AW-1:0] m_first;
        res_t          last;
        res_t          resq [$];
        acc_t          busq [$];

        task automatic begin_pass();
            m_idx   = 1;
            m_off   = DW'(m_pcnt);
            m_err   = 0;
            m_first = '0;
            for (int a = 0; a < DEPTH; a++) busq.push_back('{1'b1, AW'(a), DW'(a) + m_off});
            for (int a = 0; a < DEPTH; a++) busq.push_back('{1'b0, AW'(a), '0});
        endtask

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_idx   = 0;
                m_pcnt  = '0;
                m_off   = '0;
                m_err   = 0;
                m_first = '0;
                last    = '{16'd0, '0, 1'b0, 16'd0};
                resq.delete();
                busq.delete();
            end else begin
                if (m_idx >= DEPTH + 1 + RL && m_idx <= 2 * DEPTH + RL) begin
                    int k;
                    k = m_idx - DEPTH - 1 - RL;
                    if (ram_if.ram_rd_data != DW'(k) + m_off) begin
                        if (m_err == 0) m_first = AW'(k);
                        m_err++;
                    end
                    if (m_idx == 2 * DEPTH + RL) begin
                        m_pcnt = m_pcnt + 16'd1;
                        last.err   = (m_err > (2 ** EW - 1)) ? 16'(2 ** EW - 1) : 16'(m_err);
                        last.first = m_first;
                        last.pass  = (m_err == 0);
                        last.pcnt  = m_pcnt;
                        resq.push_back(last);
                    end
                end
                if (m_idx == 0) begin
                    if (start) begin_pass();
                end else if (m_idx == PLEN) begin
                    if (loop_en) begin_pass();
                    else m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
        end

        always @(negedge clk) begin
            if (rst_n) begin
                if (ram_if.ram_en) begin
                    if (busq.size() == 0) begin
                        chk("bus_unexpected_en", gi, 1, 0);
                    end else begin
                        acc_t a;
                        a = busq.pop_front();
                        chk("bus_we", gi, ram_if.ram_we, a.we);
                        chk("bus_addr", gi, ram_if.ram_addr, a.addr);
                        if (a.we) chk("bus_wdata", gi, ram_if.ram_wr_data, a.data);
                    end
                end
                chk("busy", gi, busy, m_idx != 0);
                if (done || m_idx == PLEN) begin
                    chk("done_timing", gi, done, m_idx == PLEN);
                    if (resq.size() == 0) begin
                        chk("done_no_result", gi, 1, 0);
                    end else begin
                        res_t r;
                        r = resq.pop_front();
                        if (done) begin
                            chk("err_cnt", gi, err_cnt, r.err);
                            chk("first_err_addr", gi, first_err_addr, r.first);
                            chk("pass", gi, pass, r.pass);
                            chk("pass_cnt", gi, pass_cnt, r.pcnt);
                            chk("bus_left_over", gi, busq.size(), 0);
                        end
                    end
                end
                if (m_idx == 0 && !done) begin
                    chk("idle_err_cnt", gi, err_cnt, last.err);
                    chk("idle_first", gi, first_err_addr, last.first);
                    chk("idle_pass", gi, pass, last.pass);
                    chk("idle_pass_cnt", gi, pass_cnt, last.pcnt);
                end
            end
        end

        always @(negedge rst_n) begin
            #1;
            chk("rst_bus", gi, {ram_if.ram_en, ram_if.ram_we, ram_if.ram_addr, ram_if.ram_wr_data}, 0);
            chk("rst_status", gi, {busy, done, pass, err_cnt, first_err_addr, pass_cnt}, 0);
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((g_dut[0].m_idx != 0 || g_dut[1].m_idx != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("wait_idle_timeout", 0, 1, 0);
        @(negedge clk);
    endtask

    task automatic clear_faults();
        for (int i = 0; i < DEPTH; i++) fault_mask[i] = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] base;
        int          n;
        start    = 1'b0;
        loop_en  = 1'b0;
        skew     = 1'b0;
        const_ff = 1'b0;
        rst_n    = 1'b0;
        clear_faults();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean single pass.
        pulse_start();
        wait_idle();

        // Stuck-at-1 bit 3 at address 5, then at 5 and 9.
        fault_mask[5] = 8'h08;
        pulse_start();
        wait_idle();
        fault_mask[9] = 8'h08;
        pulse_start();
        wait_idle();
        clear_faults();

        // Three looping passes.
        base    = g_dut[0].m_pcnt;
        loop_en = 1'b1;
        pulse_start();
        n = 0;
        while (g_dut[0].m_pcnt != base + 16'd3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("loop_timeout", 0, 1, 0);
        loop_en = 1'b0;
        wait_idle();

        // RAM one cycle slower than the engine expects.
        skew = 1'b1;
        pulse_start();
        wait_idle();
        skew = 1'b0;

        // Asynchronous reset while reading address 10, then a clean pass.
        pulse_start();
        n = 0;
        while (g_dut[0].m_idx != DEPTH + 11 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("mid_read_timeout", 0, 1, 0);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_idle();
        pulse_start();
        wait_idle();

        // Constant 0xFF read data with start pulsed while busy.
        const_ff = 1'b1;
        pulse_start();
        repeat (20) @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_idle();
        const_ff = 1'b0;

        for (int it = 0; it < 16; it++) begin
            int mode;
            clear_faults();
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                int idx;
                idx = $urandom_range(0, DEPTH - 1);
                fault_mask[idx] = fault_mask[idx] | (8'd1 << $urandom_range(0, 7));
            end
            const_ff = ($urandom_range(0, 7) == 0);
            skew     = ($urandom_range(0, 5) == 0);
            mode     = $urandom_range(0, 2);
            if (mode == 0) begin
                pulse_start();
                repeat ($urandom_range(5, 40)) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end else if (mode == 1) begin
                loop_en = 1'b1;
                pulse_start();
                repeat ($urandom_range(70, 200)) @(negedge clk);
                loop_en = 1'b0;
            end else begin
                @(negedge clk);
                start = 1'b1;
                repeat ($urandom_range(100, 220)) @(negedge clk);
                start = 1'b0;
            end
            wait_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
